// File: rtl/ula_pkg.sv
// Shared opcodes and FSM encoding for the serial logic unit.
package ula_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ula_logica_fatia.sv
// Combinational bitwise slice: y = op(a, b) over Width bits.
module ula_logica_fatia
  import ula_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [Width-1:0] y_o
);

  // Decode the opcode into one of the four gate functions.
  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/ula_logica_serial.sv
// Multi-cycle bitwise logic unit: evaluates OP(A,B) BITS_PER_CYCLE bits per
// clock, LSB chunk first, with valid/ready handshakes on both sides.
module ula_logica_serial
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULTADO,
  output logic             ZERO
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_param
    $error("BITS_PER_CYCLE must divide WIDTH");
  end

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          a_q, a_d, b_q, b_d;
  logic [1:0]                op_q, op_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          acc_q, acc_d, acc_next;
  logic [WIDTH-1:0]          res_q, res_d;
  logic                      zero_q, zero_d;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic                      last_step;

  ula_logica_fatia #(
    .Width(BITS_PER_CYCLE)
  ) u_fatia (
    .a_i (a_q[BITS_PER_CYCLE-1:0]),
    .b_i (b_q[BITS_PER_CYCLE-1:0]),
    .op_i(op_q),
    .y_o (chunk)
  );

  // Working accumulator fills from the top so the LSB chunk ends at bit 0.
  if (BITS_PER_CYCLE == WIDTH) begin : g_single
    assign acc_next = chunk;
  end else begin : g_multi
    assign acc_next = {chunk, acc_q[WIDTH-1:BITS_PER_CYCLE]};
  end

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  // State register and datapath flops, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (IN_VALID) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the visible result only updates on the final step
  // so RESULTADO/ZERO stay put while a new operation is in flight.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    res_d  = res_q;
    zero_d = zero_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d   = A;
          b_d   = B;
          op_d  = OP;
          cnt_d = '0;
          acc_d = '0;
        end
      end
      CALC: begin
        acc_d = acc_next;
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          res_d  = acc_next;
          zero_d = (acc_next == '0);
        end
      end
      default: ;
    endcase
  end

  // Handshake and result outputs, decoded from the state register.
  always_comb begin
    IN_READY  = (state_q == IDLE);
    OUT_VALID = (state_q == DONE);
    RESULTADO = res_q;
    ZERO      = zero_q;
  end

endmodule

// File: tb/tb_ula_logica_serial.sv
// Directed bench for ula_logica_serial: vector table plus handshake,
// reset and wide-slice sequences.
module tb_ula_logica_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [15:0] a, b, resultado;
  logic [1:0]  op;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, zero4;
  logic [15:0] a4, b4, resultado4;
  logic [1:0]  op4;

  int tests = 0;
  int fails = 0;

  ula_logica_serial #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .OP(op), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .RESULTADO(resultado), .ZERO(zero)
  );

  ula_logica_serial #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid4), .IN_READY(in_ready4),
    .A(a4), .B(b4), .OP(op4), .OUT_VALID(out_valid4), .OUT_READY(out_ready4),
    .RESULTADO(resultado4), .ZERO(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
    logic        z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation on the 1-bit DUT, check latency/result/zero/idle.
  task automatic run_op(input string name, input logic [15:0] xa, input logic [15:0] xb,
                        input logic [1:0] xo, input logic [15:0] er, input logic ez);
    int k;
    chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    a = xa; b = xb; op = xo; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk({name, " latency"}, k, 32'd16);
    chk({name, " result"}, {16'd0, resultado}, {16'd0, er});
    chk({name, " zero"}, {31'd0, zero}, {31'd0, ez});
    tick();
    chk({name, " idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int k;
    int n_acc, n_res, last_acc;
    logic [15:0] expq[$];
    logic [15:0] e;

    vecs[0] = '{16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 1'b0};
    vecs[1] = '{16'h1234, 16'h1234, 2'b10, 16'h0000, 1'b1};
    vecs[2] = '{16'h0F00, 16'h00F0, 2'b01, 16'h0FF0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 2'b11, 16'h0000, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 2'b11, 16'hFFFF, 1'b0};
    vecs[5] = '{16'hA5A5, 16'h5A5A, 2'b00, 16'h0000, 1'b1};
    vecs[6] = '{16'hA5A5, 16'h5A5A, 2'b10, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h8001, 16'h0000, 2'b01, 16'h8001, 1'b0};
    vecs[8] = '{16'h1234, 16'hFFFF, 2'b11, 16'hEDCB, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; op4 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset state", {15'd0, in_ready, out_valid, resultado}, {15'd0, 1'b1, 1'b0, 16'h0});
    chk("reset zero", {31'd0, zero}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].z);
    end

    // Backpressure: DONE held while new operands wait on IN_VALID.
    a = 16'h00FF; b = 16'h0F0F; op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; op = 2'b01;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("bp latency", k, 32'd16);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp hold %0d", i), {13'd0, out_valid, in_ready, zero, resultado},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h000F});
    end
    out_ready = 1'b1;
    tick();
    chk("bp back idle", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp accepted", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp result held in calc", {16'd0, resultado}, 32'h000F);
    k = 5;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk("bp second latency", k, 32'd16);
    chk("bp second result", {16'd0, resultado}, 32'hFFFF);
    tick();

    // Reset during CALC at step 7 aborts the operation.
    a = 16'hF0F0; b = 16'hFF00; op = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst mid calc", {14'd0, out_valid, in_ready, resultado}, {14'd0, 1'b0, 1'b1, 16'h0});
    tick();
    chk("rst no output", {31'd0, out_valid}, 32'd0);
    run_op("after rst", 16'hFFFF, 16'h00FF, 2'b00, 16'h00FF, 1'b0);

    // Four bits per cycle.
    a4 = 16'hFFFF; b4 = 16'h00FF; op4 = 2'b11; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    k = 0;
    while (!out_valid4 && k < 40) begin
      tick();
      k++;
    end
    chk("bpc4 latency", k, 32'd4);
    chk("bpc4 nand", {15'd0, zero4, resultado4}, {15'd0, 1'b0, 16'hFF00});
    tick();
    a4 = 16'h1234; b4 = 16'h0000; op4 = 2'b10; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    k = 0;
    while (!out_valid4 && k < 40) begin
      tick();
      k++;
    end
    chk("bpc4 xor order", {15'd0, zero4, resultado4}, {15'd0, 1'b0, 16'h1234});
    tick();

    // Streaming: accepts spaced STEPS+2 apart, results against the model.
    n_acc = 0; n_res = 0; last_acc = -1;
    a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 400 && n_res < 8; c++) begin
      logic acc;
      acc = in_ready && in_valid;
      if (acc) expq.push_back(model(a, b, op));
      tick();
      if (acc) begin
        if (last_acc >= 0) chk($sformatf("stream spacing %0d", n_acc), c - last_acc, 32'd18);
        last_acc = c;
        n_acc++;
        a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
        if (n_acc == 8) in_valid = 1'b0;
      end
      if (out_valid) begin
        e = expq.pop_front();
        chk($sformatf("stream result %0d", n_res), {15'd0, zero, resultado},
            {15'd0, (e == 16'h0), e});
        n_res++;
      end
    end
    chk("stream count", n_res, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ula_logica_serial.md
Name: ula_logica_serial

Overview:
Multi-cycle bitwise logic unit for the ULA. It is the sequential counterpart of the parallel 16-bit logic gates.
- Accepts two WIDTH-bit operands and an opcode over a valid/ready handshake.
- Evaluates the operation BITS_PER_CYCLE bits per clock, LSB chunk first.
- Returns the assembled result and a zero flag over a second valid/ready handshake.
- Sits between the operand/control path and the result register, for area-constrained builds of the ULA.

Parameters:
WIDTH, 16, operand and result width in bits.
BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH; otherwise elaboration fails.

Ports:
CLK  input  1  clock; all logic on the rising edge.
RST_N  input  1  synchronous reset, active-low.
IN_VALID  input  1  operands and opcode present.
IN_READY  output  1  unit idle, can accept an operation.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
OP  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
OUT_VALID  output  1  RESULTADO and ZERO are valid.
OUT_READY  input  1  downstream accepts the result.
RESULTADO  output  WIDTH  result of OP(A,B).
ZERO  output  1  high when RESULTADO is all zeros.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-low (RST_N), sampled on the CLK rising edge.
- Define STEPS = WIDTH/BITS_PER_CYCLE. The step counter is max(1, clog2(STEPS)) bits wide.
- On reset (RST_N=0 at an edge):
  - state=IDLE, OUT_VALID=0, RESULTADO=0, ZERO=0.
  - Counter and operand shift registers are cleared.
  - Reset has priority over every other event, including mid-operation: the operation is aborted and no output is produced.
- IN_READY = (state==IDLE). It is combinational from the state register, so it reads 1 in the first cycle after reset.
- IDLE:
  - At an edge with IN_VALID && IN_READY, latch A, B and OP into internal registers, counter=0, go to CALC.
  - Otherwise stay in IDLE. IN_VALID is ignored when IN_READY=0.
- CALC, on each edge:
  - chunk = OP applied to the low BITS_PER_CYCLE bits of the A/B shift registers.
  - Result register := {chunk, result[WIDTH-1:BITS_PER_CYCLE]}.
  - A and B shift right by BITS_PER_CYCLE; counter increments.
  - At the edge where counter==STEPS-1: go to DONE, and register ZERO from the final result value.
  - A, B and OP port changes during CALC have no effect.
- Latency: accept at edge e0; OUT_VALID is visible after edge e0+STEPS (16 cycles for the defaults).
- DONE:
  - OUT_VALID=1; RESULTADO and ZERO are held stable.
  - At an edge with OUT_READY=1, go to IDLE and OUT_VALID falls.
  - RESULTADO and ZERO keep their last values until the next operation completes or reset.
- No overlap: a new operation is accepted only from IDLE. The minimum spacing between accepts is STEPS+2 cycles.
- BITS_PER_CYCLE=WIDTH is legal: single CALC cycle, latency 1.

Decomposition:
- Package ula_pkg holds:
  - the opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11;
  - the state encoding IDLE/CALC/DONE.
- One sub-module, ula_logica_fatia: a combinational BITS_PER_CYCLE-wide slice computing OP(a,b), instantiated once in CALC.
- FSM, counter and shift registers live in the top module.

Test Plan:
1. AND: A=16'hF0F0, B=16'hFF00, OP=00, OUT_READY=1 -> OUT_VALID exactly 16 cycles after accept, RESULTADO=16'hF000, ZERO=0, IDLE one cycle later.
2. XOR zero flag: A=B=16'h1234, OP=10 -> RESULTADO=16'h0000, ZERO=1. Then OR with A=16'h0F00, B=16'h00F0 -> 16'h0FF0, ZERO=0.
3. Backpressure: hold OUT_READY=0 for 5 cycles in DONE while driving IN_VALID=1 with new operands -> OUT_VALID, RESULTADO and ZERO are stable and IN_READY=0 throughout. The new operands are not captured until after OUT_READY=1 and the return to IDLE.
4. Reset mid-CALC: assert RST_N=0 for one edge at step 7 -> next cycle OUT_VALID=0, RESULTADO=0, IN_READY=1. A following AND of 16'hFFFF & 16'h00FF completes with 16'h00FF.
5. BITS_PER_CYCLE=4 instance: NAND with A=16'hFFFF, B=16'h00FF -> RESULTADO=16'hFF00 after 4 cycles, ZERO=0.
6. Streaming: IN_VALID and OUT_READY held high with 8 random ops -> each result matches the golden model, and accepts are spaced exactly STEPS+2=18 cycles apart.
